hazard_detection_unit: RTL and testbench

Load-use hazard detector for the 5-stage RV32I pipeline, sitting between the IF/ID and ID/EX pipeline registers. When the instruction in EX is a load whose destination matches either source register of the instruction in ID, it freezes the PC and the IF/ID register and steers the control mux to inject a bubble into ID/EX. It also keeps a saturating count of stall cycles for performance observation.

---
 rtl/hazard_detection_unit.sv | 58 +++++
 tb/tb_hazard_detection_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector for the 5-stage RV32I pipeline.
// When the instruction in EX is a load whose rd feeds either source of the
// instruction in ID, the PC and IF/ID are frozen and a bubble is steered into
// ID/EX. A saturating counter records how many cycles were spent stalling.
module hazard_detection_unit #(
  parameter int IGNORE_X0 = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_Reg_Rs,
  input  logic [4:0]       IFID_Reg_Rd,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Reg_Rd,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             Mux_select,
  output logic [CNT_W-1:0] Stall_count
);

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      sat_inc = val;
    end else begin
      sat_inc = val + CNT_W'(1);
    end
  endfunction

  logic src_match;
  logic hazard;

  // Hazard equation; reset overrides it so the pipeline runs freely in reset.
  always_comb begin
    src_match = (IDEX_Reg_Rd == IFID_Reg_Rs) || (IDEX_Reg_Rd == IFID_Reg_Rd);
    hazard    = IDEX_MemRead && src_match;
    if ((IGNORE_X0 != 0) && (IDEX_Reg_Rd == 5'd0)) begin
      hazard = 1'b0;
    end
    if (!rst_n) begin
      hazard = 1'b0;
    end
  end

  assign Mux_select = hazard;
  assign PC_write   = ~hazard;
  assign IFID_write = ~hazard;

  // Stall-cycle counter, cleared asynchronously, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_count <= '0;
    end else if (hazard) begin
      Stall_count <= sat_inc(Stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: two instances (x0 compared / x0 ignored
// with a 4-bit counter) driven from shared inputs and checked against a
// behavioural model of the load-use rule and a saturating cycle tally.
`timescale 1ns/1ps
module tb_hazard_detection_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        mem_read;
  logic [4:0]  ex_rd;

  logic        pc_a, ifid_a, mux_a;
  logic [31:0] cnt_a;
  logic        pc_b, ifid_b, mux_b;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  localparam longint MAX_A = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX_B = 15;
  longint exp_a = 0;
  longint exp_b = 0;

  hazard_detection_unit #(.IGNORE_X0(0), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_Reg_Rs(rs1), .IFID_Reg_Rd(rs2),
    .IDEX_MemRead(mem_read), .IDEX_Reg_Rd(ex_rd),
    .PC_write(pc_a), .IFID_write(ifid_a), .Mux_select(mux_a),
    .Stall_count(cnt_a)
  );

  hazard_detection_unit #(.IGNORE_X0(1), .CNT_W(4)) u_dut_x0 (
    .clk(clk), .rst_n(rst_n),
    .IFID_Reg_Rs(rs1), .IFID_Reg_Rd(rs2),
    .IDEX_MemRead(mem_read), .IDEX_Reg_Rd(ex_rd),
    .PC_write(pc_b), .IFID_write(ifid_b), .Mux_select(mux_b),
    .Stall_count(cnt_b)
  );

  always #10 clk = ~clk;

  // Model: a stall happens when a load produces a register the ID instruction reads.
  function automatic bit model_stall(input bit ignore_x0);
    logic [4:0] reads [2];
    bit hit;
    reads[0] = rs1;
    reads[1] = rs2;
    hit = 1'b0;
    if (rst_n !== 1'b1) return 1'b0;
    if (mem_read !== 1'b1) return 1'b0;
    if (ignore_x0 && ex_rd == 5'd0) return 1'b0;
    foreach (reads[i]) if (reads[i] == ex_rd) hit = 1'b1;
    return hit;
  endfunction

  // Model of the stall tally: one per stalled edge, capped, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a <= 0;
      exp_b <= 0;
    end else begin
      if (model_stall(1'b0)) exp_a <= (exp_a < MAX_A) ? exp_a + 1 : exp_a;
      if (model_stall(1'b1)) exp_b <= (exp_b < MAX_B) ? exp_b + 1 : exp_b;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    bit sa, sb;
    sa = model_stall(1'b0);
    sb = model_stall(1'b1);
    check_val({tag, "_mux_a"},  64'(mux_a),  64'(sa));
    check_val({tag, "_pc_a"},   64'(pc_a),   64'(!sa));
    check_val({tag, "_ifid_a"}, 64'(ifid_a), 64'(!sa));
    check_val({tag, "_mux_b"},  64'(mux_b),  64'(sb));
    check_val({tag, "_pc_b"},   64'(pc_b),   64'(!sb));
    check_val({tag, "_ifid_b"}, 64'(ifid_b), 64'(!sb));
    check_val({tag, "_cnt_a"},  64'(cnt_a),  64'(exp_a));
    check_val({tag, "_cnt_b"},  64'(cnt_b),  64'(exp_b));
  endtask

  task automatic set_in(input logic mr, input logic [4:0] exd, input logic [4:0] a, input logic [4:0] b);
    mem_read = mr;
    ex_rd    = exd;
    rs1      = a;
    rs2      = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(1'b0, 5'd0, 5'd1, 5'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset with a hazard pattern on the inputs: outputs must stay idle.
    rst_n = 1'b0;
    set_in(1'b1, 5'd3, 5'd3, 5'd3);
    #1;
    check_val("reset_mux", 64'(mux_a), 64'd0);
    check_val("reset_pc", 64'(pc_a), 64'd1);
    check_val("reset_ifid", 64'(ifid_a), 64'd1);
    check_val("reset_cnt", 64'(cnt_a), 64'd0);
    check_all("reset");
    do_reset();

    // Zero-register load-use.
    @(negedge clk);
    set_in(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check_val("x0_mux_cmp", 64'(mux_a), 64'd1);
    check_val("x0_pc_cmp", 64'(pc_a), 64'd0);
    check_val("x0_mux_ign", 64'(mux_b), 64'd0);
    check_val("x0_pc_ign", 64'(pc_b), 64'd1);
    check_all("x0");

    // Source-match sweep.
    @(negedge clk);
    set_in(1'b1, 5'h1F, 5'h1F, 5'h1B);
    #1;
    check_val("rs1_match", 64'(mux_a), 64'd1);
    check_all("rs1_match");
    @(negedge clk);
    set_in(1'b1, 5'h1F, 5'h1B, 5'h1F);
    #1;
    check_val("rs2_match", 64'(mux_a), 64'd1);
    check_val("rs2_match_x0", 64'(mux_b), 64'd1);
    check_all("rs2_match");
    @(negedge clk);
    set_in(1'b1, 5'h1F, 5'h1B, 5'h1C);
    #1;
    check_val("no_match", 64'(mux_a), 64'd0);
    check_val("no_match_pc", 64'(pc_a), 64'd1);
    check_all("no_match");

    // Non-load never stalls.
    @(negedge clk);
    set_in(1'b0, 5'h05, 5'h05, 5'h05);
    #1;
    check_val("nonload", 64'(mux_a), 64'd0);
    check_all("nonload");

    // Counter: three stalled edges.
    do_reset();
    set_in(1'b1, 5'd7, 5'd7, 5'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 5'd7, 5'd7, 5'd3);
    #1;
    check_val("cnt3_a", 64'(cnt_a), 64'd3);
    check_val("cnt3_b", 64'(cnt_b), 64'd3);
    repeat (2) @(negedge clk);
    #1;
    check_val("cnt3_hold", 64'(cnt_a), 64'd3);
    check_all("cnt3");

    // Saturation of the 4-bit counter.
    @(negedge clk);
    set_in(1'b1, 5'd4, 5'd9, 5'd4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 5'd4, 5'd9, 5'd4);
    #1;
    check_val("sat_b", 64'(cnt_b), 64'd15);
    check_val("sat_a", 64'(cnt_a), 64'd23);
    check_all("sat");

    // Reset mid-stall, asynchronous.
    do_reset();
    set_in(1'b1, 5'd9, 5'd9, 5'd2);
    repeat (2) @(posedge clk);
    #1;
    check_val("mid_pre_cnt", 64'(cnt_a), 64'd2);
    #4;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_mux", 64'(mux_a), 64'd0);
    check_val("mid_rst_pc", 64'(pc_a), 64'd1);
    check_val("mid_rst_cnt", 64'(cnt_a), 64'd0);
    check_val("mid_rst_cnt_b", 64'(cnt_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_mux", 64'(mux_a), 64'd1);
    check_val("rel_cnt0", 64'(cnt_a), 64'd0);
    @(posedge clk);
    #1;
    check_val("rel_cnt1", 64'(cnt_a), 64'd1);
    check_all("rel");

    // Exhaustive sweep of all 16 input bits, four vectors per cycle.
    for (int v = 0; v < 65536; v++) begin
      logic [15:0] vec;
      if (v % 4 == 0) @(negedge clk);
      vec = v[15:0];
      {mem_read, ex_rd, rs1, rs2} = vec;
      #1;
      check_all("exh");
      #1;
    end

    // Randomized traffic biased toward dependencies, with occasional resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 39) != 0);
      mem_read = $urandom_range(0, 3) != 0;
      ex_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      rs1      = ($urandom_range(0, 2) == 0) ? ex_rd : 5'($urandom);
      rs2      = ($urandom_range(0, 2) == 0) ? ex_rd : 5'($urandom);
      #1;
      check_all("rand");
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
